// File: rtl/mem_select_copy_pkg.sv
// Shared defaults and helpers for the FO-transform constant-time select/copy block.
// The address width is derived from the memory depth.
package mem_select_copy_pkg;

    localparam int DEF_WIDTH         = 32;
    localparam int DEF_MAX_MEM_DEPTH = 16;

    // Address width for a given depth, never narrower than one bit.
    function automatic int clog2(input int value);
        int result;
        result = $clog2(value);
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    localparam int DEF_AW = clog2(DEF_MAX_MEM_DEPTH);

endpackage

// File: rtl/mem_select_copy_if.sv
// Job-request and memory-port bundle for mem_select_copy.
// Signal names keep the block's established i_/o_ naming as seen from the copy engine.
interface mem_select_copy_if
    import mem_select_copy_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
);

    logic             i_start;
    logic             i_fail;
    logic [AW-1:0]    i_start_addr;
    logic [AW-1:0]    i_end_addr;
    logic [AW-1:0]    i_out_start_addr;

    logic [AW-1:0]    o_mem_in_addr;
    logic             o_mem_in_en;
    logic [WIDTH-1:0] i_mem_in_k;
    logic [WIDTH-1:0] i_mem_in_s;

    logic [AW-1:0]    o_mem_out_addr;
    logic             o_mem_out_we;
    logic [WIDTH-1:0] o_mem_out_data;
    logic             o_done;

    modport slave (
        input  i_start, i_fail, i_start_addr, i_end_addr, i_out_start_addr,
        input  i_mem_in_k, i_mem_in_s,
        output o_mem_in_addr, o_mem_in_en,
        output o_mem_out_addr, o_mem_out_we, o_mem_out_data, o_done
    );

    modport master (
        output i_start, i_fail, i_start_addr, i_end_addr, i_out_start_addr,
        output i_mem_in_k, i_mem_in_s,
        input  o_mem_in_addr, o_mem_in_en,
        input  o_mem_out_addr, o_mem_out_we, o_mem_out_data, o_done
    );

endinterface

// File: rtl/mem_select_copy_ct_word_select.sv
// Branch-free word select: each bit comes from b where the mask is set, else from a.
// Reusable by any FO-transform select that must not leak the selector through timing.
module ct_word_select
#(
    parameter int WIDTH = 32
)(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] mask_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = (a_i & ~mask_i) | (b_i & mask_i);

endmodule

// File: rtl/mem_select_copy.sv
// Copies k' (pass) or s (fail) into the SHAKE-input memory with a fail-independent schedule.
// Both sources are read every cycle; only the latched mask decides which word is written.
module mem_select_copy
    import mem_select_copy_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int MAX_MEM_DEPTH = DEF_MAX_MEM_DEPTH
)(
    input  logic            i_clk,
    input  logic            i_rst,
    mem_select_copy_if.slave bus
);

    localparam int AW = clog2(MAX_MEM_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    end_q,    end_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0] mask_q,   mask_d;
    logic             rd_vld_q, rd_vld_d;

    logic             rd_en;
    logic [WIDTH-1:0] sel_word;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        end_d    = end_q;
        wr_ptr_d = wr_ptr_q;
        mask_d   = mask_q;
        rd_vld_d = rd_vld_q;

        // Write pointer follows the delayed read; rd_vld is never set while idle.
        if (rd_vld_q) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d  = S_RUN;
                    mask_d   = {WIDTH{bus.i_fail}};
                    rd_ptr_d = bus.i_start_addr;
                    end_d    = bus.i_end_addr;
                    wr_ptr_d = bus.i_out_start_addr;
                end
            end
            S_RUN: begin
                rd_vld_d = 1'b1;
                if (rd_ptr_q == end_q) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                rd_vld_d = 1'b0;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            end_q    <= '0;
            wr_ptr_q <= '0;
            mask_q   <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            end_q    <= end_d;
            wr_ptr_q <= wr_ptr_d;
            mask_q   <= mask_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    ct_word_select #(
        .WIDTH (WIDTH)
    ) u_select (
        .a_i    (bus.i_mem_in_k),
        .b_i    (bus.i_mem_in_s),
        .mask_i (mask_q),
        .y_o    (sel_word)
    );

    // Address/data buses are forced to zero when inactive so idle outputs read as 0.
    assign rd_en              = (state_q == S_RUN);
    assign bus.o_mem_in_en    = rd_en;
    assign bus.o_mem_in_addr  = rd_ptr_q & {AW{rd_en}};
    assign bus.o_mem_out_we   = rd_vld_q;
    assign bus.o_mem_out_addr = wr_ptr_q & {AW{rd_vld_q}};
    assign bus.o_mem_out_data = sel_word & {WIDTH{rd_vld_q}};
    assign bus.o_done         = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_select_copy.sv
// Directed bench for mem_select_copy: k'/s select, wrap, single word, reset abort,
// busy/back-to-back acceptance and input stability.
module tb_mem_select_copy;

    localparam logic [31:0] SENT = 32'hFFFF_FFFF;

    logic clk;
    logic rst;
    logic clr;
    int   tests;
    int   fails;

    logic [31:0] kmem [0:15];
    logic [31:0] smem [0:15];
    logic [31:0] dest [0:15];
    logic [10:0] trace      [0:39];
    logic [10:0] pass_trace [0:39];

    mem_select_copy_if #(.WIDTH(32), .AW(4)) bus ();

    mem_select_copy #(
        .WIDTH         (32),
        .MAX_MEM_DEPTH (16)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source memories: synchronous read, data one cycle after the address.
    always @(posedge clk) begin
        if (bus.o_mem_in_en) begin
            bus.i_mem_in_k <= kmem[bus.o_mem_in_addr];
            bus.i_mem_in_s <= smem[bus.o_mem_in_addr];
        end
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) dest[i] <= SENT;
        end else if (bus.o_mem_out_we) begin
            dest[bus.o_mem_out_addr] <= bus.o_mem_out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_dest();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic run_job(input logic [3:0] sa, input logic [3:0] ea, input logic [3:0] oa,
                           input logic f, input bit tgl, input int n, input string tag);
        logic       e_en, e_we, e_done;
        logic [3:0] e_ra, e_wa;
        logic [10:0] expv;
        for (int c = 0; c < n + 4; c++) begin
            if (c == 0) begin
                bus.i_start          = 1'b1;
                bus.i_fail           = f;
                bus.i_start_addr     = sa;
                bus.i_end_addr       = ea;
                bus.i_out_start_addr = oa;
            end else if (tgl && c <= n) begin
                bus.i_start          = 1'($urandom_range(0, 1));
                bus.i_fail           = ~bus.i_fail;
                bus.i_start_addr     = 4'($urandom);
                bus.i_end_addr       = 4'($urandom);
                bus.i_out_start_addr = 4'($urandom);
            end else begin
                bus.i_start = 1'b0;
            end
            #1;
            trace[c] = {bus.o_mem_in_en, bus.o_mem_in_addr, bus.o_mem_out_we,
                        bus.o_mem_out_addr, bus.o_done};
            e_en   = (c >= 1) && (c <= n);
            e_ra   = e_en ? 4'(sa + c - 1) : 4'd0;
            e_we   = (c >= 2) && (c <= n + 1);
            e_wa   = e_we ? 4'(oa + c - 2) : 4'd0;
            e_done = (c == n + 2);
            expv   = {e_en, e_ra, e_we, e_wa, e_done};
            tests++;
            assert (trace[c] === expv) else begin
                fails++;
                $error("FAIL %s ctrl cycle %0d: got %h expected %h", tag, c, trace[c], expv);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_dest(input logic [3:0] sa, input logic [3:0] oa, input logic f,
                              input int n, input string tag);
        logic [3:0]  si, di;
        logic [31:0] expv;
        for (int i = 0; i < n; i++) begin
            si   = 4'(sa + i);
            di   = 4'(oa + i);
            expv = f ? (32'h2000 + 32'(si)) : (32'h1000 + 32'(si));
            tests++;
            assert (dest[di] === expv) else begin
                fails++;
                $error("FAIL %s dest[%0d]: got %h expected %h", tag, di, dest[di], expv);
            end
        end
        di = 4'(oa + n);
        tests++;
        assert (dest[di] === SENT) else begin
            fails++;
            $error("FAIL %s untouched dest[%0d]: got %h expected %h", tag, di, dest[di], SENT);
        end
    endtask

    initial begin
        logic [42:0] outs;
        logic [8:0]  en_seen, done_seen;
        int          cnt;
        bit          same;

        tests = 0;
        fails = 0;
        clr   = 1'b0;
        rst   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            kmem[i] = 32'h1000 + 32'(i);
            smem[i] = 32'h2000 + 32'(i);
        end
        bus.i_start          = 1'b0;
        bus.i_fail           = 1'b0;
        bus.i_start_addr     = '0;
        bus.i_end_addr       = '0;
        bus.i_out_start_addr = '0;

        step();
        step();
        outs = {bus.o_mem_in_en, bus.o_mem_in_addr, bus.o_mem_out_we, bus.o_mem_out_addr,
                bus.o_done, bus.o_mem_out_data};
        tests++;
        assert (outs === 43'd0) else begin
            fails++;
            $error("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst = 1'b0;
        step();

        // Pass: k' words land at dest[8..11]
        clear_dest();
        run_job(4'd0, 4'd3, 4'd8, 1'b0, 1'b0, 4, "pass");
        check_dest(4'd0, 4'd8, 1'b0, 4, "pass");
        for (int i = 0; i < 8; i++) pass_trace[i] = trace[i];

        // Fail: s words, control identical to pass
        clear_dest();
        run_job(4'd0, 4'd3, 4'd8, 1'b1, 1'b0, 4, "fail");
        check_dest(4'd0, 4'd8, 1'b1, 4, "fail");
        same = 1'b1;
        for (int i = 0; i < 8; i++) if (trace[i] !== pass_trace[i]) same = 1'b0;
        tests++;
        assert (same === 1'b1) else begin
            fails++;
            $error("FAIL const_time: got differing=%0d expected 0", !same);
        end

        clear_dest();
        run_job(4'd5, 4'd5, 4'd0, 1'b0, 1'b0, 1, "single");
        check_dest(4'd5, 4'd0, 1'b0, 1, "single");

        clear_dest();
        run_job(4'd14, 4'd1, 4'd15, 1'b1, 1'b0, 4, "wrap");
        check_dest(4'd14, 4'd15, 1'b1, 4, "wrap");

        // Reset asserted in cycle 3 of an 8-word job
        clear_dest();
        bus.i_start = 1'b1;
        bus.i_fail = 1'b0;
        bus.i_start_addr = 4'd0;
        bus.i_end_addr = 4'd7;
        bus.i_out_start_addr = 4'd4;
        step();
        bus.i_start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        outs = {bus.o_mem_in_en, bus.o_mem_in_addr, bus.o_mem_out_we, bus.o_mem_out_addr,
                bus.o_done, bus.o_mem_out_data};
        tests++;
        assert (outs === 43'd0) else begin
            fails++;
            $error("FAIL abort_outputs: got %h expected 0", outs);
        end
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.o_mem_out_we || bus.o_done || bus.o_mem_in_en) cnt++;
            step();
        end
        tests++;
        assert (cnt === 0) else begin
            fails++;
            $error("FAIL abort_quiet: got %0d active cycles expected 0", cnt);
        end
        tests++;
        assert (dest[5] === 32'h1001 && dest[6] === SENT) else begin
            fails++;
            $error("FAIL abort_dest: got %h/%h expected 00001001/%h", dest[5], dest[6], SENT);
        end
        clear_dest();
        run_job(4'd9, 4'd10, 4'd3, 1'b0, 1'b0, 2, "after_abort");
        check_dest(4'd9, 4'd3, 1'b0, 2, "after_abort");

        // Inputs scrambled during RUN must not disturb the latched job
        clear_dest();
        run_job(4'd2, 4'd5, 4'd10, 1'b0, 1'b1, 4, "stable");
        check_dest(4'd2, 4'd10, 1'b0, 4, "stable");
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.o_mem_in_en || bus.o_mem_out_we) cnt++;
            step();
        end
        tests++;
        assert (cnt === 0) else begin
            fails++;
            $error("FAIL stable_no_second: got %0d active cycles expected 0", cnt);
        end

        // i_start held through S_DONE: accepted only in the following idle cycle
        bus.i_start = 1'b1;
        bus.i_fail = 1'b0;
        bus.i_start_addr = 4'd6;
        bus.i_end_addr = 4'd6;
        bus.i_out_start_addr = 4'd1;
        en_seen = '0;
        done_seen = '0;
        for (int c = 0; c < 9; c++) begin
            if (c == 5) bus.i_start = 1'b0;
            #1;
            en_seen[c] = bus.o_mem_in_en;
            done_seen[c] = bus.o_done;
            @(posedge clk);
            #1;
        end
        tests++;
        assert (en_seen === 9'b000100010) else begin
            fails++;
            $error("FAIL b2b_reads: got %b expected %b", en_seen, 9'b000100010);
        end
        tests++;
        assert (done_seen === 9'b010001000) else begin
            fails++;
            $error("FAIL b2b_done: got %b expected %b", done_seen, 9'b010001000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
